// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: MIPS memory
//                opcodes, the controller state enumeration and small opcode
//                classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Address bits that must be zero for the access width of this opcode.
  function automatic logic [1:0] op_align_mask(input logic [5:0] op);
    logic [1:0] mask;
    mask = 2'b00;
    if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) mask = 2'b01;
    if ((op == OP_LW) || (op == OP_SW))                   mask = 2'b11;
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic. Extracts and sign/zero-extends the
//                addressed byte/halfword of a memory word for loads, and
//                merges store data into the addressed lane(s) for sb/sh.
//  Ports       : opcode     - registered MIPS opcode
//                byte_off   - address[1:0] of the access
//                word       - memory word read back
//                store_data - low halfword of the store operand
//                load_data  - extended load result
//                merged     - word with target lane(s) replaced
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = word[{byte_off, 3'b000} +: 8];
    lane_half = byte_off[1] ? word[31:16] : word[15:0];

    case (opcode)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'd0, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'd0, lane_half};
      default: load_data = word;
    endcase

    merged = word;
    if (opcode == OP_SB) begin
      merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
    end else if (opcode == OP_SH) begin
      if (byte_off[1]) merged[31:16] = store_data;
      else             merged[15:0]  = store_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-request MIPS load/store unit in front of a
//                word-addressed memory with a ready handshake. Sub-word
//                stores are done as read-modify-write.
//  Ports       : clk, reset (async, active high)
//                req_valid/req_ready, opcode, address, write_data - request
//                done, load_data, misalign, illegal            - completion
//                mem_addr, mem_re, mem_we, mem_wdata,
//                mem_rdata, mem_ready                          - memory side
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [5:0]    opcode,
  input  logic [31:0]   address,
  input  logic [31:0]   write_data,
  output logic          done,
  output logic [31:0]   load_data,
  output logic          misalign,
  output logic          illegal,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  lsu_state_t    state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misalign_q, misalign_d;
  logic          illegal_q, illegal_d;

  logic [31:0]   ext_data;
  logic [31:0]   merged_word;
  logic          req_legal;

  // Address bits above the word index wrap and are deliberately dropped.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^address[31:AW+2];

  lsu_align u_align (
    .opcode     (op_q),
    .byte_off   (addr_q[1:0]),
    .word       (rdata_q),
    .store_data (wdata_q[15:0]),
    .load_data  (ext_data),
    .merged     (merged_word)
  );

  assign req_legal = op_is_load(opcode) || op_is_store(opcode);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    illegal_d  = illegal_q;
    req_ready  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = opcode;
          addr_d     = address[AW+1:0];
          wdata_d    = write_data;
          illegal_d  = !req_legal;
          misalign_d = req_legal && ((address[1:0] & op_align_mask(opcode)) != 2'b00);
          if (!req_legal || ((address[1:0] & op_align_mask(opcode)) != 2'b00))
            state_d = ST_DONE;
          else if (opcode == OP_SW)
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = op_is_load(op_q) ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        mem_we = 1'b1;
        if (mem_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs come straight from registered request fields, so they
  // hold steady for as long as the memory stalls.
  assign mem_addr  = (mem_re || mem_we) ? addr_q[AW+1:2] : '0;
  assign mem_wdata = mem_we ? ((op_q == OP_SW) ? wdata_q : merged_word) : 32'd0;
  assign load_data = (done && !misalign_q && !illegal_q && op_is_load(op_q)) ? ext_data : 32'd0;
  assign misalign  = done && misalign_q;
  assign illegal   = done && illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
    end
  end

endmodule
`default_nettype wire
